// File: rtl/seq_verify_pkg.sv
// Shared types, ASCII constants, error codes and helpers for the seq_verify_num frame parser.
// The SEQ_VERIFY_ERRCODE_EN macro adds an err_code output; the constants here are always present.
package seq_verify_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    SIGN  = 3'd2,
    DIG0  = 3'd3,
    DIGS  = 3'd4,
    CLOSE = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_NUL    = 8'h00;
  localparam logic [7:0] ASCII_LPAREN = 8'h28;
  localparam logic [7:0] ASCII_RPAREN = 8'h29;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_OPEN  = 3'd1;
  localparam logic [2:0] ERR_DIGIT = 3'd2;
  localparam logic [2:0] ERR_COUNT = 3'd3;
  localparam logic [2:0] ERR_CLOSE = 3'd4;

  // Returns {is_digit, nibble}; hex mode accepts upper-case 'A'-'F' only.
  function automatic logic [4:0] digit_decode(input logic [7:0] c, input bit hex);
    logic [4:0] r;
    logic [7:0] d;
    r = '0;
    d = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      d = c - 8'h30;
      r = {1'b1, d[3:0]};
    end else if (hex && c >= 8'h41 && c <= 8'h46) begin
      d = c - 8'h37;
      r = {1'b1, d[3:0]};
    end
    return r;
  endfunction

  // Smallest value width that holds the largest magnitude of the given digit count plus a sign bit.
  function automatic int min_val_w(input int digits, input int hex);
    longint m;
    int bits;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * ((hex != 0) ? 16 : 10);
    m = m - 1;
    bits = 0;
    while (m > 0) begin
      bits++;
      m = m >> 1;
    end
    return bits + 1;
  endfunction

endpackage

// File: rtl/seq_verify_num_if.sv
// Character-in / verdict-out bundle for seq_verify_num; dbg_state exposes the parser FSM.
// err_code exists only when SEQ_VERIFY_ERRCODE_EN is defined.
interface seq_verify_num_if #(
  parameter int VAL_W = 16
);
  import seq_verify_pkg::*;

  // ascii_char is sampled only on clock edges where char_valid is high; there is no
  // back-pressure, every qualified character is consumed. Verdict outputs are levels,
  // output_strobe is the only pulse.
  logic [7:0]       ascii_char;
  logic             char_valid;
  logic             sequence_valid;
  logic             output_strobe;
  logic [VAL_W-1:0] value;
  logic [7:0]       good_cnt;
  logic [7:0]       bad_cnt;
`ifdef SEQ_VERIFY_ERRCODE_EN
  logic [2:0]       err_code;
`endif
  state_t           dbg_state;

  modport master (
    output ascii_char, char_valid,
    input  sequence_valid, output_strobe, value, good_cnt, bad_cnt,
`ifdef SEQ_VERIFY_ERRCODE_EN
    input  err_code,
`endif
    input  dbg_state
  );

  modport slave (
    input  ascii_char, char_valid,
    output sequence_valid, output_strobe, value, good_cnt, bad_cnt,
`ifdef SEQ_VERIFY_ERRCODE_EN
    output err_code,
`endif
    output dbg_state
  );

endinterface

// File: rtl/seq_strobe_timer.sv
// Down-counter that holds strobe high for STROBE_LEN cycles after each restart;
// a restart while running reloads the full length so the strobe stays continuous.
module seq_strobe_timer #(
  parameter int STROBE_LEN = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic strobe
);

  localparam int CW = $clog2(STROBE_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(STROBE_LEN);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign strobe = (cnt_q != '0);

endmodule

// File: rtl/seq_verify_num.sv
// Parses NUL-delimited "(" [sign] digits ")" frames from a character stream and reports a
// verdict, signed value and good/bad counts. Define SEQ_VERIFY_ERRCODE_EN to add err_code.
module seq_verify_num
  import seq_verify_pkg::*;
#(
  parameter int MAX_DIGITS   = 4,
  parameter int HEX_MODE     = 0,
  parameter int VAL_W        = 16,
  parameter int UART_TX_baud = 20,
  parameter int freq         = 200
) (
  input logic             clk,
  input logic             rst,
  seq_verify_num_if.slave bus
);

  localparam int STROBE_LEN = freq / UART_TX_baud;
  localparam logic [VAL_W-1:0] RADIX = (HEX_MODE != 0) ? VAL_W'(16) : VAL_W'(10);
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 8) begin : g_bad_digits
    $error("seq_verify_num: MAX_DIGITS must be in 1..8");
  end
  if (VAL_W < min_val_w(MAX_DIGITS, HEX_MODE)) begin : g_bad_val_w
    $error("seq_verify_num: VAL_W too small for MAX_DIGITS digits plus sign");
  end
  if (STROBE_LEN < 1) begin : g_bad_strobe
    $error("seq_verify_num: freq/UART_TX_baud must be at least 1");
  end

  state_t           state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic             seq_valid_q;
  logic [VAL_W-1:0] value_q;
  logic [7:0]       good_q;
  logic [7:0]       bad_q;

  logic             fire;
  logic             fire_ok;
  logic             go_open;
  logic             is_dig;
  logic [3:0]       nib;
  logic [7:0]       ch;
  logic             strobe;

  assign ch = bus.ascii_char;
  assign {is_dig, nib} = digit_decode(bus.ascii_char, HEX_MODE != 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    fire    = 1'b0;
    fire_ok = 1'b0;
    go_open = 1'b0;
    if (bus.char_valid) begin
      case (state_q)
        IDLE: begin
          if (ch == ASCII_NUL) go_open = 1'b1;
        end
        OPEN: begin
          if (ch == ASCII_NUL) go_open = 1'b1;
          else if (ch == ASCII_LPAREN) state_d = SIGN;
          else state_d = ERR;
        end
        SIGN: begin
          if (ch == ASCII_PLUS) begin
            state_d = DIG0;
            neg_d   = 1'b0;
          end else if (ch == ASCII_MINUS) begin
            state_d = DIG0;
            neg_d   = 1'b1;
          end else if (is_dig) begin
            state_d = DIGS;
            acc_d   = {{(VAL_W-4){1'b0}}, nib};
            cnt_d   = 4'd1;
          end else if (ch == ASCII_NUL) begin
            fire    = 1'b1;
            go_open = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
        DIG0: begin
          if (is_dig) begin
            state_d = DIGS;
            acc_d   = {{(VAL_W-4){1'b0}}, nib};
            cnt_d   = 4'd1;
          end else if (ch == ASCII_NUL) begin
            fire    = 1'b1;
            go_open = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
        DIGS: begin
          if (is_dig) begin
            if (cnt_q < MAX_CNT) begin
              acc_d = acc_q * RADIX + {{(VAL_W-4){1'b0}}, nib};
              cnt_d = cnt_q + 4'd1;
            end else begin
              state_d = ERR;
            end
          end else if (ch == ASCII_RPAREN) begin
            state_d = CLOSE;
          end else if (ch == ASCII_NUL) begin
            fire    = 1'b1;
            go_open = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
        CLOSE: begin
          if (ch == ASCII_NUL) begin
            fire    = 1'b1;
            fire_ok = 1'b1;
            go_open = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
        ERR: begin
          if (ch == ASCII_NUL) begin
            fire    = 1'b1;
            go_open = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // The terminating NUL of a frame doubles as the opening NUL of the next one.
    if (go_open) begin
      state_d = OPEN;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_valid_q <= 1'b0;
      value_q     <= '0;
      good_q      <= '0;
      bad_q       <= '0;
    end else if (fire) begin
      seq_valid_q <= fire_ok;
      if (fire_ok) begin
        value_q <= neg_q ? -acc_q : acc_q;
        good_q  <= good_q + 8'd1;
      end else begin
        bad_q   <= bad_q + 8'd1;
      end
    end
  end

`ifdef SEQ_VERIFY_ERRCODE_EN
  logic [2:0] code_q, code_d;
  logic [2:0] err_code_q;

  // Remembers why the frame entered ERR so the verdict on the closing NUL can report it.
  always_comb begin
    code_d = code_q;
    if (bus.char_valid) begin
      case (state_q)
        OPEN: if (ch != ASCII_NUL && ch != ASCII_LPAREN) code_d = ERR_OPEN;
        SIGN: if (!is_dig && ch != ASCII_PLUS && ch != ASCII_MINUS && ch != ASCII_NUL)
                code_d = ERR_DIGIT;
        DIG0: if (!is_dig && ch != ASCII_NUL) code_d = ERR_DIGIT;
        DIGS: begin
          if (is_dig && cnt_q >= MAX_CNT) code_d = ERR_COUNT;
          else if (!is_dig && ch != ASCII_RPAREN && ch != ASCII_NUL) code_d = ERR_DIGIT;
        end
        CLOSE: if (ch != ASCII_NUL) code_d = ERR_CLOSE;
        default: code_d = code_q;
      endcase
    end
    if (go_open) code_d = ERR_NONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q     <= ERR_NONE;
      err_code_q <= ERR_NONE;
    end else begin
      code_q <= code_d;
      if (fire) begin
        if (fire_ok) err_code_q <= ERR_NONE;
        else if (state_q == ERR) err_code_q <= code_q;
        else err_code_q <= ERR_CLOSE;
      end
    end
  end

  assign bus.err_code = err_code_q;
`endif

  seq_strobe_timer #(
    .STROBE_LEN(STROBE_LEN)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .restart (fire),
    .strobe  (strobe)
  );

  assign bus.sequence_valid = seq_valid_q;
  assign bus.output_strobe  = strobe;
  assign bus.value          = value_q;
  assign bus.good_cnt       = good_q;
  assign bus.bad_cnt        = bad_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_seq_verify_num.sv
// Scoreboard bench for seq_verify_num: a decimal instance (defaults) and a hex instance
// (MAX_DIGITS=3) driven with directed frames; monitors check verdicts and strobe lengths.
module tb_seq_verify_num;
  import seq_verify_pkg::*;

  typedef struct packed {
    logic        vld;
    logic [15:0] value;
    logic [7:0]  good;
    logic [7:0]  bad;
    logic [2:0]  code;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_verify_num_if #(.VAL_W(16)) if_dec ();
  seq_verify_num_if #(.VAL_W(16)) if_hex ();

  seq_verify_num #(
    .MAX_DIGITS(4), .HEX_MODE(0), .VAL_W(16), .UART_TX_baud(20), .freq(200)
  ) u_dec (
    .clk (clk),
    .rst (rst),
    .bus (if_dec.slave)
  );

  seq_verify_num #(
    .MAX_DIGITS(3), .HEX_MODE(1), .VAL_W(16), .UART_TX_baud(20), .freq(200)
  ) u_hex (
    .clk (clk),
    .rst (rst),
    .bus (if_hex.slave)
  );

  // scoreboard state
  exp_t exp_dec_q[$];
  exp_t exp_hex_q[$];
  int   pulse_dec_q[$];
  int   pulse_hex_q[$];
  int   good_m[2];
  int   bad_m[2];
  logic [15:0] val_m[2];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // driver tasks
  task automatic send_char(input int d, input logic [7:0] c);
    @(negedge clk);
    if (d == 0) begin
      if_dec.ascii_char = c;
      if_dec.char_valid = 1'b1;
      if_hex.char_valid = 1'b0;
    end else begin
      if_hex.ascii_char = c;
      if_hex.char_valid = 1'b1;
      if_dec.char_valid = 1'b0;
    end
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) send_char(d, s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if_dec.char_valid = 1'b0;
      if_hex.char_valid = 1'b0;
    end
  endtask

  task automatic expect_verdict(input int d, input bit vld, input int v, input logic [2:0] code);
    exp_t e;
    if (vld) begin
      good_m[d] = (good_m[d] + 1) % 256;
      val_m[d]  = 16'(v);
    end else begin
      bad_m[d] = (bad_m[d] + 1) % 256;
    end
    e = '{vld: vld, value: val_m[d], good: 8'(good_m[d]), bad: 8'(bad_m[d]), code: code};
    if (d == 0) exp_dec_q.push_back(e);
    else exp_hex_q.push_back(e);
  endtask

  task automatic expect_pulse(input int d, input int len);
    if (d == 0) pulse_dec_q.push_back(len);
    else pulse_hex_q.push_back(len);
  endtask

  // One frame with its terminating NUL, single verdict, then let the strobe run out.
  task automatic frame(input int d, input string s, input bit vld, input int v, input logic [2:0] code);
    expect_verdict(d, vld, v, code);
    expect_pulse(d, 10);
    send_str(d, s);
    send_char(d, ASCII_NUL);
    idle(14);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dec sequence_valid"}, 32'(if_dec.sequence_valid), 32'd0);
    check({tag, " dec output_strobe"}, 32'(if_dec.output_strobe), 32'd0);
    check({tag, " dec value"}, 32'(if_dec.value), 32'd0);
    check({tag, " dec good_cnt"}, 32'(if_dec.good_cnt), 32'd0);
    check({tag, " dec bad_cnt"}, 32'(if_dec.bad_cnt), 32'd0);
    check({tag, " dec state"}, 32'(if_dec.dbg_state), 32'(IDLE));
    check({tag, " hex value"}, 32'(if_hex.value), 32'd0);
    check({tag, " hex good_cnt"}, 32'(if_hex.good_cnt), 32'd0);
`ifdef SEQ_VERIFY_ERRCODE_EN
    check({tag, " dec err_code"}, 32'(if_dec.err_code), 32'd0);
`endif
  endtask

  // verdict monitors: a verdict is visible as a counter step
  function automatic void check_verdict(input int d, input logic vld, input logic [15:0] v,
                                        input logic [7:0] g, input logic [7:0] b,
                                        input logic [2:0] code, input logic strb);
    exp_t  e;
    string n;
    n = (d == 0) ? "dec" : "hex";
    if ((d == 0 && exp_dec_q.size() == 0) || (d == 1 && exp_hex_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected verdict: got valid=%0b good=%0d bad=%0d expected none", n, vld, g, b);
      return;
    end
    e = (d == 0) ? exp_dec_q.pop_front() : exp_hex_q.pop_front();
    check({n, " sequence_valid"}, 32'(vld), 32'(e.vld));
    check({n, " value"}, 32'(v), 32'(e.value));
    check({n, " good_cnt"}, 32'(g), 32'(e.good));
    check({n, " bad_cnt"}, 32'(b), 32'(e.bad));
    check({n, " strobe with verdict"}, 32'(strb), 32'd1);
`ifdef SEQ_VERIFY_ERRCODE_EN
    check({n, " err_code"}, 32'(code), 32'(e.code));
`else
    if (code != 3'd0) $display("note: unexpected code argument %0d", code);
`endif
  endfunction

  logic [7:0] prev_g_dec, prev_b_dec, prev_g_hex, prev_b_hex;
  logic [2:0] code_dec, code_hex;
`ifdef SEQ_VERIFY_ERRCODE_EN
  assign code_dec = if_dec.err_code;
  assign code_hex = if_hex.err_code;
`else
  assign code_dec = 3'd0;
  assign code_hex = 3'd0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      prev_g_dec = '0;
      prev_b_dec = '0;
    end else if (if_dec.good_cnt !== prev_g_dec || if_dec.bad_cnt !== prev_b_dec) begin
      check_verdict(0, if_dec.sequence_valid, if_dec.value, if_dec.good_cnt, if_dec.bad_cnt,
                    code_dec, if_dec.output_strobe);
      prev_g_dec = if_dec.good_cnt;
      prev_b_dec = if_dec.bad_cnt;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_g_hex = '0;
      prev_b_hex = '0;
    end else if (if_hex.good_cnt !== prev_g_hex || if_hex.bad_cnt !== prev_b_hex) begin
      check_verdict(1, if_hex.sequence_valid, if_hex.value, if_hex.good_cnt, if_hex.bad_cnt,
                    code_hex, if_hex.output_strobe);
      prev_g_hex = if_hex.good_cnt;
      prev_b_hex = if_hex.bad_cnt;
    end
  end

  // strobe monitors: measure each high run and compare on its falling edge
  int run_dec = 0;
  int run_hex = 0;

  function automatic void check_pulse(input int d, input int len);
    int e;
    if ((d == 0 && pulse_dec_q.size() == 0) || (d == 1 && pulse_hex_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected strobe: got %0d cycles expected none", (d == 0) ? "dec" : "hex", len);
      return;
    end
    e = (d == 0) ? pulse_dec_q.pop_front() : pulse_hex_q.pop_front();
    check((d == 0) ? "dec strobe length" : "hex strobe length", 32'(len), 32'(e));
  endfunction

  always @(negedge clk) begin
    if (!rst) run_dec = 0;
    else if (if_dec.output_strobe) run_dec++;
    else if (run_dec > 0) begin
      check_pulse(0, run_dec);
      run_dec = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) run_hex = 0;
    else if (if_hex.output_strobe) run_hex++;
    else if (run_hex > 0) begin
      check_pulse(1, run_hex);
      run_hex = 0;
    end
  end

  // stimulus
  initial begin
    rst = 1'b0;
    if_dec.ascii_char = 8'h00;
    if_dec.char_valid = 1'b0;
    if_hex.ascii_char = 8'h00;
    if_hex.char_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      good_m[i] = 0;
      bad_m[i]  = 0;
      val_m[i]  = '0;
    end
    idle(3);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // decimal instance
    send_char(0, ASCII_NUL);
    frame(0, "(+12)", 1'b1, 12, ERR_NONE);
    frame(0, "(+1A)", 1'b0, 0, ERR_DIGIT);
    frame(0, "(-305)", 1'b1, -305, ERR_NONE);
    frame(0, "(+12345)", 1'b0, 0, ERR_COUNT);
    frame(0, "(7)", 1'b1, 7, ERR_NONE);
    frame(0, "x", 1'b0, 0, ERR_OPEN);
    frame(0, "(+)", 1'b0, 0, ERR_DIGIT);
    frame(0, "(+1)x", 1'b0, 0, ERR_CLOSE);

    // empty frame: a second NUL yields no verdict
    send_char(0, ASCII_NUL);
    idle(14);
    check("dec good_cnt after double NUL", 32'(if_dec.good_cnt), 32'(good_m[0]));
    check("dec bad_cnt after double NUL", 32'(if_dec.bad_cnt), 32'(bad_m[0]));

    // second verdict lands 3 cycles into the first strobe: one 3+10 cycle pulse
    expect_verdict(0, 1'b1, 1, ERR_NONE);
    expect_verdict(0, 1'b0, 0, ERR_CLOSE);
    expect_pulse(0, 13);
    send_str(0, "(+1)");
    send_char(0, ASCII_NUL);
    send_str(0, "(5");
    send_char(0, ASCII_NUL);
    idle(16);

    // hex instance
    send_char(1, ASCII_NUL);
    frame(1, "(+1A)", 1'b1, 'h1A, ERR_NONE);
    frame(1, "(7F", 1'b0, 0, ERR_CLOSE);
    frame(1, "(-FF)", 1'b1, -255, ERR_NONE);
    frame(1, "(1234)", 1'b0, 0, ERR_COUNT);

    // reset in the middle of a frame
    send_str(0, "(+1");
    @(negedge clk);
    if_dec.char_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    for (int i = 0; i < 2; i++) begin
      good_m[i] = 0;
      bad_m[i]  = 0;
      val_m[i]  = '0;
    end
    idle(3);
    rst = 1'b1;
    idle(2);
    // IDLE ignores a whole frame until a NUL arrives
    send_str(0, "(+9)");
    send_char(0, ASCII_NUL);
    frame(0, "(+5)", 1'b1, 5, ERR_NONE);

    // drain, bounded
    for (int i = 0; i < 100; i++) begin
      if (exp_dec_q.size() == 0 && exp_hex_q.size() == 0 &&
          pulse_dec_q.size() == 0 && pulse_hex_q.size() == 0) break;
      @(negedge clk);
    end
    check("dec verdicts outstanding", 32'(exp_dec_q.size()), 32'd0);
    check("hex verdicts outstanding", 32'(exp_hex_q.size()), 32'd0);
    check("dec strobes outstanding", 32'(pulse_dec_q.size()), 32'd0);
    check("hex strobes outstanding", 32'(pulse_hex_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
